// File: rtl/param_sync_fifo.sv
// Single-clock show-ahead FIFO with occupancy level, almost-full/almost-empty
// thresholds and sticky overflow/underflow flags.
module param_sync_fifo #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_LEVEL  = 3,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enqueue_request,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       dequeue_request,
    output logic [WIDTH-1:0]           data_out,
    output logic                       is_empty,
    output logic                       is_full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       clear_errors
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_LVL  = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AFULL_LVL  = PTR_W'(AFULL_LEVEL);
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_LEVEL);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] level_r;
    logic             is_empty_r;
    logic             is_full_r;
    logic             almost_empty_r;
    logic             almost_full_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             do_enq_s;
    logic             do_deq_s;
    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [PTR_W-1:0] level_nxt_s;
    logic             overflow_nxt_s;
    logic             underflow_nxt_s;

    // Accept decisions, next-state pointers and sticky error next-state.
    always_comb begin
        do_enq_s        = enqueue_request & ~is_full_r;
        do_deq_s        = dequeue_request & ~is_empty_r;
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;

        if (do_enq_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (do_deq_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        // Wrap bit makes the plain difference the true occupancy 0..DEPTH.
        level_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;

        // A new error in the same cycle as a clear keeps the flag set.
        if (enqueue_request & is_full_r) begin
            overflow_nxt_s = 1'b1;
        end else if (clear_errors) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end

        if (dequeue_request & is_empty_r) begin
            underflow_nxt_s = 1'b1;
        end else if (clear_errors) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // Pointer, level, flag and error state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            level_r        <= {PTR_W{1'b0}};
            is_empty_r     <= 1'b1;
            is_full_r      <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
        end else begin
            wr_ptr_r       <= wr_ptr_nxt_s;
            rd_ptr_r       <= rd_ptr_nxt_s;
            level_r        <= level_nxt_s;
            is_empty_r     <= (level_nxt_s == {PTR_W{1'b0}});
            is_full_r      <= (level_nxt_s == DEPTH_LVL);
            almost_empty_r <= (level_nxt_s <= AEMPTY_LVL);
            almost_full_r  <= (level_nxt_s >= AFULL_LVL);
            overflow_r     <= overflow_nxt_s;
            underflow_r    <= underflow_nxt_s;
        end
    end

    // Storage write port; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_enq_s) begin
            mem_r[wr_ptr_r[ADDR_W-1:0]] <= data_in;
        end
    end

    assign data_out     = mem_r[rd_ptr_r[ADDR_W-1:0]];
    assign is_empty     = is_empty_r;
    assign is_full      = is_full_r;
    assign almost_empty = almost_empty_r;
    assign almost_full  = almost_full_r;
    assign level        = level_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Table-driven bench for param_sync_fifo (WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1)
// with a data scoreboard fed by accepted enqueues and drained by accepted dequeues.
module tb_param_sync_fifo;

    typedef struct packed {
        logic [2:0] level;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
        logic       ov;
        logic       un;
    } exp_t;

    typedef struct packed {
        logic       enq;
        logic       deq;
        logic       clr;
        logic [7:0] din;
        exp_t       e;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       enqueue_request;
    logic [7:0] data_in;
    logic       dequeue_request;
    logic [7:0] data_out;
    logic       is_empty;
    logic       is_full;
    logic       almost_empty;
    logic       almost_full;
    logic [2:0] level;
    logic       overflow;
    logic       underflow;
    logic       clear_errors;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q [$];
    vec_t       vq   [$];
    logic       m_full;
    logic       m_empty;

    param_sync_fifo #(
        .WIDTH(8), .DEPTH(4), .AFULL_LEVEL(3), .AEMPTY_LEVEL(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enqueue_request(enqueue_request),
        .data_in(data_in),
        .dequeue_request(dequeue_request),
        .data_out(data_out),
        .is_empty(is_empty),
        .is_full(is_full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .level(level),
        .overflow(overflow),
        .underflow(underflow),
        .clear_errors(clear_errors)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic chk_state(input string name, input exp_t e);
        chk({name, ".level"},     int'(level),        int'(e.level));
        chk({name, ".empty"},     int'(is_empty),     int'(e.empty));
        chk({name, ".full"},      int'(is_full),      int'(e.full));
        chk({name, ".aempty"},    int'(almost_empty), int'(e.ae));
        chk({name, ".afull"},     int'(almost_full),  int'(e.af));
        chk({name, ".overflow"},  int'(overflow),     int'(e.ov));
        chk({name, ".underflow"}, int'(underflow),    int'(e.un));
    endtask

    function automatic exp_t mk_e(input int lv, input logic em, input logic fu,
                                  input logic ae, input logic af,
                                  input logic ov, input logic un);
        exp_t e;
        e.level = 3'(lv);
        e.empty = em;
        e.full  = fu;
        e.ae    = ae;
        e.af    = af;
        e.ov    = ov;
        e.un    = un;
        return e;
    endfunction

    function automatic vec_t mk_v(input logic enq, input logic deq, input logic clr,
                                  input logic [7:0] din, input exp_t e);
        vec_t v;
        v.enq = enq;
        v.deq = deq;
        v.clr = clr;
        v.din = din;
        v.e   = e;
        return v;
    endfunction

    // One cycle: drive at negedge, check head against scoreboard, check state after edge.
    task automatic step(input vec_t v, input string name);
        logic [7:0] exp_d;
        @(negedge clk);
        enqueue_request = v.enq;
        dequeue_request = v.deq;
        clear_errors    = v.clr;
        data_in         = v.din;
        #1;
        if (v.deq && !m_empty) begin
            if (sb_q.size() == 0) begin
                chk({name, ".sb_nonempty"}, 0, 1);
            end else begin
                exp_d = sb_q.pop_front();
                chk({name, ".data_out"}, int'(data_out), int'(exp_d));
            end
        end
        if (v.enq && !m_full) sb_q.push_back(v.din);
        @(posedge clk);
        #1;
        chk_state(name, v.e);
        m_full  = v.e.full;
        m_empty = v.e.empty;
        enqueue_request = 1'b0;
        dequeue_request = 1'b0;
        clear_errors    = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        enqueue_request = 1'b0;
        dequeue_request = 1'b0;
        clear_errors    = 1'b0;
        data_in         = 8'h00;
        m_full          = 1'b0;
        m_empty         = 1'b1;

        repeat (2) @(negedge clk);
        chk_state("reset", mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;

        // Fill/overflow/drain, underflow/clear, full+both, empty+both with clear.
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hA0, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hA1, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hA2, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hA3, mk_e(4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hA4, mk_e(4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b0, 1'b1, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)));
        vq.push_back(mk_v(1'b0, 1'b0, 1'b1, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hB0, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hB1, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hB2, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b0, 1'b0, 8'hB3, mk_e(4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b1, 1'b0, 8'hB4, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0)));
        vq.push_back(mk_v(1'b1, 1'b1, 1'b1, 8'hC0, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)));
        vq.push_back(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1)));
        vq.push_back(mk_v(1'b0, 1'b0, 1'b1, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)));

        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i], $sformatf("vec%0d", i));
        end

        // Wrap: prime with 2 words, then simultaneous enqueue/dequeue for 20 cycles.
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hE0, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "prime0");
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hE1, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)), "prime1");
        for (int i = 0; i < 20; i++) begin
            step(mk_v(1'b1, 1'b1, 1'b0, 8'(i), mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)),
                 $sformatf("wrap%0d", i));
        end
        step(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "wdrain0");
        step(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "wdrain1");

        // Mid-clock reset with level=3 and overflow set.
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hD0, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "rfill0");
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hD1, mk_e(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)), "rfill1");
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hD2, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)), "rfill2");
        step(mk_v(1'b1, 1'b0, 1'b0, 8'hD3, mk_e(4, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0)), "rfill3");
        step(mk_v(1'b1, 1'b1, 1'b0, 8'hD4, mk_e(3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)), "rboth");
        #2;
        reset = 1'b1;
        #1;
        chk_state("midreset", mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        sb_q.delete();
        m_full  = 1'b0;
        m_empty = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(mk_v(1'b1, 1'b0, 1'b0, 8'h55, mk_e(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "post_enq");
        chk("post_head", int'(data_out), 8'h55);
        step(mk_v(1'b0, 1'b1, 1'b0, 8'h00, mk_e(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)), "post_deq");
        chk("sb_empty_at_end", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
